cond_sink_burst: RTL and testbench

Clocked, parametrised successor to the dual-rail conditional sink. It accepts one control token per burst. The token carries a dual-rail pass/drop choice and a burst length. The next `ctl_len+1` data tokens are then either forwarded through an output FIFO of `DEPTH` entries or consumed and counted. It sits between a data producer and a consumer wherever a stream must be filtered in bursts under control of a separate decision channel.

---
 rtl/cond_sink_burst.sv | 160 ++++++++++++++++
 tb/tb_cond_sink_burst.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cond_sink_burst.sv
`timescale 1ns/1ps
// Burst-controlled conditional sink: one control token selects whether the next
// ctl_len+1 data tokens are forwarded through an output FIFO or dropped and counted.
module cond_sink_burst #(
  parameter int N     = 32,
  parameter int DEPTH = 4,   // power of two, >= 2
  parameter int LW    = 4,
  parameter int CW    = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r_i,
  output logic          a_i,
  input  logic [N-1:0]  d_i,
  input  logic          ctl_a,
  input  logic          ctl_b,
  input  logic [LW-1:0] ctl_len,
  output logic          actl_i,
  output logic          r_o,
  input  logic          a_o,
  output logic [N-1:0]  d_o,
  output logic [CW-1:0] drop_cnt,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [LW-1:0] rem_q, rem_d;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [N-1:0]  mem_q [DEPTH];

  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic          err_q, err_d;

  logic ctl_fire, data_fire, push, pop, fifo_full;

  assign fifo_full = (count_q == (AW+1)'(DEPTH));
  assign ctl_fire  = actl_i & (ctl_a | ctl_b);
  assign data_fire = a_i & r_i;
  assign push      = data_fire & (state_q == PASS);
  assign pop       = r_o & a_o;

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Next-state logic.
  // NOTE: defaults at the top of every combinational block prevent latches.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (ctl_fire) begin
          rem_d   = ctl_len;
          state_d = (ctl_a & ~ctl_b) ? PASS : DROP;
        end
      end
      PASS, DROP: begin
        if (data_fire) begin
          if (rem_q == '0) state_d = IDLE;
          else             rem_d   = rem_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs: held low throughout reset, otherwise a function of state
  // and FIFO fullness only, so no combinational path from any request.
  always_comb begin
    actl_i = 1'b0;
    a_i    = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE:    actl_i = 1'b1;
        PASS:    a_i    = ~fifo_full;
        DROP:    a_i    = 1'b1;
        default: ;
      endcase
    end
  end

  // FIFO control.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= d_i;
  end

  assign r_o = (count_q != '0);
  assign d_o = mem_q[rd_ptr_q];

  // Drop counter saturates; error flag is sticky until reset.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_d      = err_q;
    if (data_fire && state_q == DROP && drop_cnt_q != '1)
      drop_cnt_d = drop_cnt_q + 1'b1;
    if (ctl_fire && ctl_a && ctl_b)
      err_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_q      <= err_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign err      = err_q;

endmodule

// File: tb/tb_cond_sink_burst.sv
`timescale 1ns/1ps
// Scoreboard bench for cond_sink_burst: a full-width instance and a 2-bit-counter
// instance share all inputs; the monitor checks forwarded data in order.
module tb_cond_sink_burst;

  localparam int N = 32, DEPTH = 4, LW = 4, CW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          r_i = 1'b0, a_o = 1'b0, ctl_a = 1'b0, ctl_b = 1'b0;
  logic [N-1:0]  d_i = '0;
  logic [LW-1:0] ctl_len = '0;

  logic          a_i, actl_i, r_o, err;
  logic [N-1:0]  d_o;
  logic [CW-1:0] drop_cnt;

  logic          s_a_i, s_actl_i, s_r_o, s_err;
  logic [N-1:0]  s_d_o;
  logic [1:0]    s_drop_cnt;

  int n_checks = 0;
  int n_pass   = 0;
  logic [N-1:0] exp_q [$];

  always #5 clk = ~clk;

  cond_sink_burst #(.N(N), .DEPTH(DEPTH), .LW(LW), .CW(CW)) u_dut (
    .clk(clk), .rst(rst), .r_i(r_i), .a_i(a_i), .d_i(d_i),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .ctl_len(ctl_len), .actl_i(actl_i),
    .r_o(r_o), .a_o(a_o), .d_o(d_o), .drop_cnt(drop_cnt), .err(err)
  );

  cond_sink_burst #(.N(N), .DEPTH(DEPTH), .LW(LW), .CW(2)) u_sat (
    .clk(clk), .rst(rst), .r_i(r_i), .a_i(s_a_i), .d_i(d_i),
    .ctl_a(ctl_a), .ctl_b(ctl_b), .ctl_len(ctl_len), .actl_i(s_actl_i),
    .r_o(s_r_o), .a_o(a_o), .d_o(s_d_o), .drop_cnt(s_drop_cnt), .err(s_err)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
  endtask

  // Control token: held until actl_i is seen high before a rising edge.
  task automatic send_ctl(input logic pa, input logic pb, input logic [LW-1:0] len);
    logic hs;
    hs = 1'b0;
    ctl_a = pa; ctl_b = pb; ctl_len = len;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = actl_i;
      @(posedge clk); #1;
    end
    ctl_a = 1'b0; ctl_b = 1'b0;
    check("ctl handshake", hs, 1);
  endtask

  // Data token; when it goes to the FIFO its value is queued as expected output.
  task automatic send_data(input logic [N-1:0] d, input bit to_fifo);
    logic hs;
    hs = 1'b0;
    r_i = 1'b1; d_i = d;
    for (int i = 0; i < 50 && !hs; i++) begin
      @(negedge clk);
      hs = a_i;
      if (hs && to_fifo) exp_q.push_back(d);
      @(posedge clk); #1;
    end
    r_i = 1'b0;
    check("data handshake", hs, 1);
  endtask

  // Monitor: every output transfer must match the oldest expected token.
  always @(negedge clk) begin
    if (!rst && r_o && a_o) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected output at %0t: got %0h, expected nothing", $time, d_o);
      end else begin
        check("fifo order", d_o, exp_q.pop_front());
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    #1;
    check("rst a_i", a_i, 0);
    check("rst actl_i", actl_i, 0);
    check("rst r_o", r_o, 0);
    check("rst drop_cnt", drop_cnt, 0);
    check("rst err", err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("actl_i after release", actl_i, 1);
    check("a_i idle", a_i, 0);

    // Pass single
    a_o = 1'b1;
    send_ctl(1'b1, 1'b0, 4'd0);
    check("a_i in pass", a_i, 1);
    send_data(32'hDEADBEEF, 1'b1);
    check("pass r_o", r_o, 1);
    check("pass d_o", d_o, 32'hDEADBEEF);
    check("pass actl_i", actl_i, 1);
    @(posedge clk); #1;
    check("pass drained", r_o, 0);

    // Drop burst of 4, saturating twin counts 1,2,3,3
    a_o = 1'b0;
    send_ctl(1'b0, 1'b1, 4'd3);
    for (int k = 0; k < 4; k++) begin
      send_data(32'h100 + k, 1'b0);
      check("drop a_i", a_i, (k < 3) ? 1 : 0);
      check("drop r_o", r_o, 0);
      check("sat cnt", s_drop_cnt, (k < 2) ? k + 1 : 3);
    end
    check("drop_cnt 4", drop_cnt, 4);
    check("drop end actl_i", actl_i, 1);
    r_i = 1'b1; d_i = 32'h104;
    repeat (3) begin
      @(negedge clk);
      check("5th not acked", a_i, 0);
    end
    @(posedge clk); #1;
    r_i = 1'b0;
    check("drop_cnt after 5th", drop_cnt, 4);

    // FIFO full, backpressure, simultaneous push/pop
    send_ctl(1'b1, 1'b0, 4'd5);
    for (int v = 1; v <= 4; v++) send_data(N'(v), 1'b1);
    check("a_i full", a_i, 0);
    check("r_o full", r_o, 1);
    r_i = 1'b1; d_i = 32'd5;
    repeat (2) begin
      @(negedge clk);
      check("held off while full", a_i, 0);
    end
    @(posedge clk); #1;
    a_o = 1'b1;
    send_data(32'd5, 1'b1);
    check("push+pop keeps count", a_i, 1);
    send_data(32'd6, 1'b1);
    check("burst end actl_i", actl_i, 1);
    repeat (6) @(posedge clk);
    #1;
    check("fifo drained queue", exp_q.size(), 0);
    check("fifo drained r_o", r_o, 0);

    // Illegal control token
    check("err before", err, 0);
    send_ctl(1'b1, 1'b1, 4'd0);
    check("err set", err, 1);
    check("sat err set", s_err, 1);
    check("illegal is drop", a_i, 1);
    send_data(32'h55, 1'b0);
    check("illegal drop_cnt", drop_cnt, 5);
    check("sat holds at 3", s_drop_cnt, 3);
    check("illegal r_o", r_o, 0);
    check("illegal end actl_i", actl_i, 1);

    // Asynchronous reset mid-cycle during a drop burst
    send_ctl(1'b0, 1'b1, 4'd2);
    send_data(32'h66, 1'b0);
    check("drop_cnt 6", drop_cnt, 6);
    check("mid drop a_i", a_i, 1);
    #3 rst = 1'b1;
    #1;
    exp_q.delete();
    check("async rst a_i", a_i, 0);
    check("async rst actl_i", actl_i, 0);
    check("async rst r_o", r_o, 0);
    check("async rst drop_cnt", drop_cnt, 0);
    check("async rst err", err, 0);
    check("async rst sat cnt", s_drop_cnt, 0);
    check("async rst sat err", s_err, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("release actl_i", actl_i, 1);
    check("release a_i", a_i, 0);

    // Reset mid pass burst with tokens stuck in the FIFO
    a_o = 1'b0;
    send_ctl(1'b1, 1'b0, 4'd7);
    send_data(32'hA1, 1'b1);
    send_data(32'hA2, 1'b1);
    check("mid pass r_o", r_o, 1);
    check("mid pass sat r_o", s_r_o, 1);
    check("mid pass a_i", a_i, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_q.delete();
    check("pass rst r_o", r_o, 0);
    check("pass rst drop_cnt", drop_cnt, 0);
    check("pass rst sat r_o", s_r_o, 0);
    @(posedge clk); #1 rst = 1'b0;
    #1;
    check("idle after rst actl_i", actl_i, 1);
    check("idle after rst a_i", a_i, 0);

    // Fresh burst after reset
    a_o = 1'b1;
    send_ctl(1'b1, 1'b0, 4'd0);
    send_data(32'hBEEF0001, 1'b1);
    check("post rst r_o", r_o, 1);
    check("post rst d_o", d_o, 32'hBEEF0001);
    repeat (3) @(posedge clk);
    #1;
    check("final queue empty", exp_q.size(), 0);
    check("final r_o", r_o, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
